// File: rtl/decode_seq_pkg.sv
// rtl/decode_seq_pkg.sv - shared types, flag bit positions and the base decode table
package decode_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB, OP_XOR, OP_NOR, OP_AND, OP_ROT, OP_ROI, OP_JLR,
    OP_JLI, OP_BXX, OP_RSV_A, OP_RSV_B, OP_ADI, OP_STB, OP_LDB, OP_LDI
  } base_op_e;

  localparam int ALU_CI  = 7;
  localparam int ALU_NB  = 6;
  localparam int ALU_IC  = 5;
  localparam int ALU_NA  = 4;
  localparam int ALU_XO  = 3;
  localparam int ALU_NO  = 2;
  localparam int ALU_ROT = 1;

  localparam int CTL_WPC = 7;
  localparam int CTL_SPC = 6;
  localparam int CTL_MW  = 5;
  localparam int CTL_MR  = 4;
  localparam int CTL_LD  = 3;
  localparam int CTL_B2  = 2;
  localparam int CTL_B1  = 1;
  localparam int CTL_B0  = 0;

  typedef struct packed {
    logic       valid;
    logic       last;
    logic [7:0] alu;
    logic [7:0] ctrl;
  } base_word_t;

  function automatic logic [7:0] fb(input int idx);
    return 8'(1) << idx;
  endfunction

  // Only step 0 of the sixteen base opcodes is populated; everything else is an empty slot.
  function automatic base_word_t default_word(input int unsigned op, input int unsigned st);
    base_word_t w;
    w.valid = 1'b0;
    w.last  = 1'b1;
    w.alu   = '0;
    w.ctrl  = '0;
    if (st == 0 && op < 16) begin
      w.valid = 1'b1;
      case (base_op_e'(op[3:0]))
        OP_ADD: ;
        OP_SUB: w.alu = fb(ALU_CI) | fb(ALU_NB);
        OP_XOR: w.alu = fb(ALU_IC);
        OP_NOR: w.alu = fb(ALU_IC) | fb(ALU_XO) | fb(ALU_NO);
        OP_AND: w.alu = fb(ALU_NB) | fb(ALU_IC) | fb(ALU_NA) | fb(ALU_XO) | fb(ALU_NO);
        OP_ROT: w.alu = fb(ALU_ROT);
        OP_ROI: begin
          w.alu  = fb(ALU_ROT);
          w.ctrl = fb(CTL_SPC);
        end
        OP_JLR: w.ctrl = fb(CTL_MR) | fb(CTL_LD);
        OP_JLI: w.ctrl = fb(CTL_MW) | fb(CTL_LD);
        OP_BXX: w.ctrl = fb(CTL_WPC) | fb(CTL_MW);
        OP_ADI: w.ctrl = fb(CTL_SPC);
        OP_STB: w.ctrl = fb(CTL_SPC) | fb(CTL_B2);
        OP_LDB: w.ctrl = fb(CTL_SPC) | fb(CTL_B1);
        OP_LDI: w.ctrl = fb(CTL_B0);
        default: w.valid = 1'b0;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/decode_seq_if.sv
// rtl/decode_seq_if.sv - opcode in / microword out handshake bundle
interface decode_seq_if #(
  parameter int OP_W   = 4,
  parameter int STEPS  = 4,
  parameter int FLAG_W = 8
);
  localparam int SW = $clog2(STEPS);

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_opcode;
  logic              out_valid;
  logic              out_ready;
  logic [FLAG_W-1:0] alu_flags;
  logic [FLAG_W-1:0] ctrl_flags;
  logic [SW-1:0]     step;
  logic              last;
  logic              illegal;

  modport master (
    output in_valid, in_opcode, out_ready,
    input  in_ready, out_valid, alu_flags, ctrl_flags, step, last, illegal
  );

  modport slave (
    input  in_valid, in_opcode, out_ready,
    output in_ready, out_valid, alu_flags, ctrl_flags, step, last, illegal
  );
endinterface

// File: rtl/decode_seq_store.sv
// rtl/decode_seq_store.sv - microprogram table; writable flops with DECODE_SEQ_WRITE_EN, else constant ROM
module decode_seq_store
  import decode_seq_pkg::*;
#(
  parameter  int OP_W   = 4,
  parameter  int STEPS  = 4,
  parameter  int FLAG_W = 8,
  localparam int SW     = $clog2(STEPS),
  localparam int AW     = OP_W + SW,
  localparam int DW     = 2 * FLAG_W + 2
) (
`ifdef DECODE_SEQ_WRITE_EN
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
`endif
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  function automatic logic [DW-1:0] default_entry(input int unsigned a);
    base_word_t w;
    w = default_word(a >> SW, a & (STEPS - 1));
    return {w.valid, w.last, FLAG_W'(w.alu), FLAG_W'(w.ctrl)};
  endfunction

`ifdef DECODE_SEQ_WRITE_EN
  logic [DW-1:0] mem [2**AW];

  // Reads are combinational from the flops, so a same-cycle write is seen only after the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) begin
        mem[i] <= default_entry(32'(i));
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];
`else
  assign rd_data = default_entry(32'(rd_addr));
`endif

endmodule

// File: rtl/decode_seq.sv
// rtl/decode_seq.sv - micro-sequenced opcode decoder; DECODE_SEQ_WRITE_EN adds the store write port
module decode_seq
  import decode_seq_pkg::*;
#(
  parameter  int OP_W   = 4,
  parameter  int STEPS  = 4,
  parameter  int FLAG_W = 8,
  localparam int SW     = $clog2(STEPS),
  localparam int AW     = OP_W + SW,
  localparam int DW     = 2 * FLAG_W + 2
) (
  input logic clk,
  input logic rst_n,
  decode_seq_if.slave bus
`ifdef DECODE_SEQ_WRITE_EN
  ,
  input logic          wr_en,
  input logic [AW-1:0] wr_addr,
  input logic [DW-1:0] wr_data
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state;
  logic [OP_W-1:0]   op_q;
  logic [SW-1:0]     step_q;
  logic              out_valid_q;
  logic              last_q;
  logic              illegal_q;
  logic [FLAG_W-1:0] alu_q;
  logic [FLAG_W-1:0] ctrl_q;

  logic              accept;
  logic              advance;
  logic [OP_W-1:0]   ld_op;
  logic [SW-1:0]     ld_step;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic              e_valid;
  logic              e_last;
  logic [FLAG_W-1:0] e_alu;
  logic [FLAG_W-1:0] e_ctrl;
  logic              e_end;

  // A finishing microword frees the decoder in the same cycle, giving one-per-cycle issue.
  assign bus.in_ready = rst_n & ((state == S_IDLE) | (out_valid_q & bus.out_ready & last_q));
  assign accept       = bus.in_valid & bus.in_ready;
  assign advance      = (state == S_RUN) & bus.out_ready & ~last_q;

  assign ld_op   = accept ? bus.in_opcode : op_q;
  assign ld_step = accept ? '0 : step_q + SW'(1);
  assign rd_addr = {ld_op, ld_step};

  decode_seq_store #(
    .OP_W  (OP_W),
    .STEPS (STEPS),
    .FLAG_W(FLAG_W)
  ) u_store (
`ifdef DECODE_SEQ_WRITE_EN
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
`endif
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  assign e_valid = rd_data[DW-1];
  assign e_last  = rd_data[DW-2];
  assign e_alu   = rd_data[2*FLAG_W-1:FLAG_W];
  assign e_ctrl  = rd_data[FLAG_W-1:0];
  assign e_end   = e_last | ~e_valid | (ld_step == SW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      illegal_q   <= 1'b0;
      alu_q       <= '0;
      ctrl_q      <= '0;
    end else begin
      case (state)
        S_IDLE, S_RUN: begin
          if (accept || advance) begin
            state       <= S_RUN;
            op_q        <= ld_op;
            step_q      <= ld_step;
            out_valid_q <= 1'b1;
            last_q      <= e_end;
            illegal_q   <= ~e_valid;
            alu_q       <= e_valid ? e_alu : '0;
            ctrl_q      <= e_valid ? e_ctrl : '0;
          end else if (state == S_RUN && bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.alu_flags  = alu_q;
  assign bus.ctrl_flags = ctrl_q;
  assign bus.step       = step_q;
  assign bus.last       = last_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_decode_seq.sv
// tb/tb_decode_seq.sv - randomized scoreboard bench for decode_seq; DECODE_SEQ_WRITE_EN enables store rewrite tests
module tb_decode_seq;
  localparam int OP_W   = 4;
  localparam int STEPS  = 4;
  localparam int FLAG_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_seq_if #(.OP_W(OP_W), .STEPS(STEPS), .FLAG_W(FLAG_W)) bus ();

`ifdef DECODE_SEQ_WRITE_EN
  logic        wr_en   = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [17:0] wr_data = '0;
`endif

  decode_seq #(.OP_W(OP_W), .STEPS(STEPS), .FLAG_W(FLAG_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef DECODE_SEQ_WRITE_EN
    ,
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
`endif
  );

  typedef struct packed {
    logic [7:0] alu;
    logic [7:0] ctrl;
    logic [1:0] step;
    logic       last;
    logic       illegal;
  } exp_t;

  exp_t q[$];
  exp_t got_w, exp_w, stall_word;
  logic had_stall = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic       m_valid [16][4];
  logic       m_last  [16][4];
  logic [7:0] m_alu   [16][4];
  logic [7:0] m_ctrl  [16][4];

  logic       acc_pending = 1'b0;
  logic [3:0] acc_op      = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic model_reset();
    logic [7:0] da[16];
    logic [7:0] dc[16];
    da = '{8'h00, 8'hC0, 8'h20, 8'h2C, 8'h7C, 8'h02, 8'h02, 8'h00,
           8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    dc = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h18,
           8'h28, 8'hA0, 8'h00, 8'h00, 8'h40, 8'h44, 8'h42, 8'h01};
    for (int op = 0; op < 16; op++) begin
      for (int s = 0; s < STEPS; s++) begin
        m_valid[op][s] = (s == 0) && (op != 10) && (op != 11);
        m_last[op][s]  = 1'b1;
        m_alu[op][s]   = (s == 0) ? da[op] : 8'h00;
        m_ctrl[op][s]  = (s == 0) ? dc[op] : 8'h00;
      end
    end
  endtask

  // Expand an issued opcode into the full list of microwords it must produce.
  task automatic push_expected(input int op);
    for (int s = 0; s < STEPS; s++) begin
      exp_t e;
      logic v;
      v         = m_valid[op][s];
      e.alu     = v ? m_alu[op][s] : 8'h00;
      e.ctrl    = v ? m_ctrl[op][s] : 8'h00;
      e.step    = 2'(s);
      e.illegal = !v;
      e.last    = !v || m_last[op][s] || (s == STEPS - 1);
      q.push_back(e);
      if (e.last) break;
    end
  endtask

  task automatic cycle(input logic iv, input logic [3:0] op, input logic ordy);
    @(posedge clk);
    if (acc_pending) push_expected(int'(acc_op));
    #1;
    bus.in_valid  = iv;
    bus.in_opcode = op;
    bus.out_ready = ordy;
    @(negedge clk);
    acc_pending = bus.in_valid & bus.in_ready;
    acc_op      = bus.in_opcode;
  endtask

  task automatic check_reset();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_alu", bus.alu_flags, 0);
    check("rst_ctrl", bus.ctrl_flags, 0);
    check("rst_step", bus.step, 0);
    check("rst_last", bus.last, 0);
    check("rst_illegal", bus.illegal, 0);
    check("rst_in_ready", bus.in_ready, 0);
  endtask

  task automatic reset_cycles(input int n);
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    acc_pending   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      q.delete();
      had_stall = 1'b0;
      model_reset();
      check_reset();
    end
    rst_n = 1'b1;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 4'h0, 1'b1);
      #1;
      if (q.size() == 0 && !acc_pending && !bus.out_valid) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_idle", done, 1);
  endtask

`ifdef DECODE_SEQ_WRITE_EN
  task automatic wr(input int op, input int st, input logic v, input logic l,
                    input logic [7:0] a, input logic [7:0] c);
    wr_en   = 1'b1;
    wr_addr = {4'(op), 2'(st)};
    wr_data = {v, l, a, c};
    m_valid[op][st] = v;
    m_last[op][st]  = l;
    m_alu[op][st]   = a;
    m_ctrl[op][st]  = c;
    cycle(1'b0, 4'h0, 1'b1);
    wr_en = 1'b0;
  endtask
`endif

  // Output monitor: every presented microword is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      got_w = {bus.alu_flags, bus.ctrl_flags, bus.step, bus.last, bus.illegal};
      check("out_valid", bus.out_valid, q.size() != 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() != 0) begin
          exp_w = q.pop_front();
          check("word", got_w, exp_w);
        end
        had_stall = 1'b0;
      end else if (bus.out_valid) begin
        if (had_stall) check("stall_hold", got_w, stall_word);
        check("stall_in_ready", bus.in_ready, 0);
        stall_word = got_w;
        had_stall  = 1'b1;
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.out_ready = 1'b0;
    model_reset();
    reset_cycles(3);

    cycle(1'b1, 4'h1, 1'b1);
    drain();

    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 4'(i), 1'b1);
      check("b2b_accept", acc_pending, 1);
    end
    drain();

    cycle(1'b1, 4'hD, 1'b1);
    repeat (3) begin
      cycle(1'b0, 4'h0, 1'b0);
      check("stall_flags", {bus.alu_flags, bus.ctrl_flags}, 16'h0044);
    end
    drain();

    for (int i = 0; i < 300; i++) begin
      cycle(($urandom % 4) != 0, 4'($urandom), ($urandom % 4) != 0);
    end
    drain();

`ifdef DECODE_SEQ_WRITE_EN
    wr(4, 0, 1'b1, 1'b0, 8'h11, 8'h21);
    wr(4, 1, 1'b1, 1'b0, 8'h12, 8'h22);
    wr(4, 2, 1'b1, 1'b1, 8'h13, 8'h23);
    cycle(1'b1, 4'h4, 1'b1);
    drain();
    for (int s = 0; s < STEPS; s++) begin
      wr(4, s, 1'b1, 1'b0, 8'($urandom), 8'($urandom));
    end
    cycle(1'b1, 4'h4, 1'b1);
    drain();
    wr(5, 0, 1'b1, 1'b0, 8'h55, 8'h66);
    wr(5, 1, 1'b0, 1'b0, 8'hFF, 8'hFF);
    cycle(1'b1, 4'h5, 1'b1);
    drain();
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom % 3) != 0, 4'($urandom), ($urandom % 3) != 0);
    end
    drain();
`endif

    cycle(1'b1, 4'h4, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0);
    reset_cycles(2);
    cycle(1'b0, 4'h0, 1'b1);
    check("post_rst_valid", bus.out_valid, 0);
    cycle(1'b1, 4'h4, 1'b1);
    drain();

    for (int i = 0; i < 200; i++) begin
      cycle(($urandom % 4) != 0, 4'($urandom), ($urandom % 4) != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
